// File: rtl/sr_jk_pkg.sv
// Shared mode encodings and the per-bit next-state rule for the sr_jk_register bank.
package sr_jk_pkg;

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // SR with S=R=1 holds; the invalid condition itself is flagged at the bank level.
    function automatic logic next_bit(input logic [1:0] mode, input logic s, input logic r,
                                      input logic q);
        logic nq;
        nq = q;
        unique case (mode)
            MODE_SR: begin
                case ({s, r})
                    2'b10:   nq = 1'b1;
                    2'b01:   nq = 1'b0;
                    default: nq = q;
                endcase
            end
            MODE_JK: begin
                case ({s, r})
                    2'b10:   nq = 1'b1;
                    2'b01:   nq = 1'b0;
                    2'b11:   nq = ~q;
                    default: nq = q;
                endcase
            end
            MODE_D:  nq = s;
            MODE_T:  nq = q ^ s;
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_jk_cell.sv
// One-bit registered storage cell; mode-dependent update, with load taking precedence over en.
module sr_jk_cell
    import sr_jk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       s,
    input  logic       r,
    input  logic       load,
    input  logic       load_val,
    output logic       q
);

    logic q_d;

    always_comb begin
        q_d = q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = next_bit(mode, s, r, q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/sr_jk_register.sv
// WIDTH-bit SR/JK/D/T register bank with sticky invalid-SR flag and saturating event counter.
// Define SR_JK_REGISTER_LOAD_EN to add the load / load_val parallel-load ports.
module sr_jk_register
    import sr_jk_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     r,
    input  logic                 err_clr,
`ifdef SR_JK_REGISTER_LOAD_EN
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
`endif
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     q_bar,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CntMax = '1;

    logic             do_load;
    logic [WIDTH-1:0] load_data;

`ifdef SR_JK_REGISTER_LOAD_EN
    assign do_load   = load;
    assign load_data = load_val;
`else
    assign do_load   = 1'b0;
    assign load_data = '0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_jk_cell u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .mode     (mode),
            .s        (s[i]),
            .r        (r[i]),
            .load     (do_load),
            .load_val (load_data[i]),
            .q        (q[i])
        );
    end

    assign q_bar = ~q;

    logic                 invalid;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    // One event per edge, however many bits have S=R=1; a load edge never logs.
    assign invalid = en & ~do_load & (mode == MODE_SR) & (|(s & r));

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (err_clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end else if (invalid) begin
            err_d = 1'b1;
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_sr_jk_register.sv
// Scoreboard bench for sr_jk_register: driver queues expected state, monitor pops and compares.
module tb_sr_jk_register;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s;
    logic [7:0] r;
    logic       err_clr;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic       err;
    logic [3:0] err_cnt;
`ifdef SR_JK_REGISTER_LOAD_EN
    logic       load;
    logic [7:0] load_val;
`endif

    sr_jk_register #(
        .WIDTH     (8),
        .ERR_CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .s        (s),
        .r        (r),
        .err_clr  (err_clr),
`ifdef SR_JK_REGISTER_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .q        (q),
        .q_bar    (q_bar),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    typedef struct {
        logic [7:0] q;
        logic       err;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever outputs are presented, compare against every queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (q !== e.q || q_bar !== ~e.q || err !== e.err || err_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL %s: got q=%h q_bar=%h err=%b cnt=%0d, want q=%h q_bar=%h err=%b cnt=%0d",
                             e.name, q, q_bar, err, err_cnt, e.q, ~e.q, e.err, e.cnt);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] eq, input logic ee, input logic [3:0] ec,
                            input string nm);
        exp_t e;
        e.q = eq; e.err = ee; e.cnt = ec; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Drive one edge's inputs, queue the expected post-edge state, present at the negedge.
    task automatic step(input logic e, input logic [1:0] m, input logic [7:0] sv,
                        input logic [7:0] rv, input logic c, input logic [7:0] eq,
                        input logic ee, input logic [3:0] ec, input string nm);
        en = e; mode = m; s = sv; r = rv; err_clr = c;
        @(posedge clk);
        #1;
        push_exp(eq, ee, ec, nm);
        @(negedge clk);
        ->sample_ev;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; s = '0; r = '0; err_clr = 1'b0;
`ifdef SR_JK_REGISTER_LOAD_EN
        load = 1'b0; load_val = '0;
`endif
        repeat (2) @(negedge clk);
        push_exp(8'h00, 1'b0, 4'd0, "reset_initial");
        ->sample_ev;
        rst_n = 1'b1;

        // Log one error, then load A5 so the reset check has something to clear.
        step(1, 2'b00, 8'h01, 8'h01, 0, 8'h00, 1, 4'd1, "sr_invalid_from_zero");
        step(1, 2'b10, 8'hA5, 8'h00, 0, 8'hA5, 1, 4'd1, "d_load_a5");

        // Asynchronous reset mid-cycle, checked before any further clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        push_exp(8'h00, 1'b0, 4'd0, "async_reset_immediate");
        ->sample_ev;
        @(negedge clk);
        push_exp(8'h00, 1'b0, 4'd0, "reset_held_over_edge");
        ->sample_ev;
        rst_n = 1'b1;

        step(1, 2'b00, 8'h0F, 8'hF0, 0, 8'h0F, 0, 4'd0, "sr_set_reset");
        step(1, 2'b00, 8'h01, 8'h01, 0, 8'h0F, 1, 4'd1, "sr_invalid_hold");
        step(0, 2'b00, 8'h00, 8'h00, 1, 8'h0F, 0, 4'd0, "errclr_with_en0");
        step(1, 2'b01, 8'hFF, 8'hFF, 0, 8'hF0, 0, 4'd0, "jk_toggle_1");
        step(1, 2'b01, 8'hFF, 8'hFF, 0, 8'h0F, 0, 4'd0, "jk_toggle_2");
        step(1, 2'b01, 8'h30, 8'h03, 0, 8'h3C, 0, 4'd0, "jk_set_reset_hold");
        step(1, 2'b00, 8'h81, 8'h42, 0, 8'hBD, 0, 4'd0, "sr_mixed_valid");
        step(1, 2'b10, 8'h3C, 8'h00, 0, 8'h3C, 0, 4'd0, "d_mode");
        step(1, 2'b11, 8'hFF, 8'h00, 0, 8'hC3, 0, 4'd0, "t_mode_all");
        step(0, 2'b10, 8'h55, 8'h00, 0, 8'hC3, 0, 4'd0, "en0_hold");
        step(0, 2'b00, 8'hFF, 8'hFF, 0, 8'hC3, 0, 4'd0, "en0_no_error");
        step(1, 2'b11, 8'h0F, 8'hAA, 0, 8'hCC, 0, 4'd0, "t_mode_partial");

        // 20 invalid edges: counter saturates at 15.
        for (int i = 1; i <= 20; i++) begin
            step(1, 2'b00, 8'hFF, 8'hFF, 0, 8'hCC, 1, (i > 15) ? 4'd15 : 4'(i), "sat_run");
        end
        step(1, 2'b00, 8'hFF, 8'hFF, 1, 8'hCC, 0, 4'd0, "errclr_beats_invalid");
        step(1, 2'b00, 8'h10, 8'h10, 0, 8'hCC, 1, 4'd1, "count_resumes");

`ifdef SR_JK_REGISTER_LOAD_EN
        load = 1'b1; load_val = 8'h5A;
        step(1, 2'b00, 8'hFF, 8'hFF, 0, 8'h5A, 1, 4'd1, "load_overrides_sr");
        load_val = 8'hC6;
        step(0, 2'b01, 8'hFF, 8'hFF, 1, 8'hC6, 0, 4'd0, "load_en0_errclr");
        load = 1'b0;
        step(1, 2'b00, 8'h01, 8'h01, 0, 8'hC6, 1, 4'd1, "after_load_invalid");
`endif

        #1;
        ->sample_ev;
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_jk_register.md
Name: sr_jk_register

Overview:
- Parametrised, edge-triggered successor to the team's gated SR storage element: a WIDTH-bit register bank with a run-time selectable flip-flop mode (SR, JK, D, T).
- Replaces the level-sensitive, race-prone S=R=1 behaviour of the latch with a defined hold plus invalid-input detection.
- Adds a sticky error flag and a saturating error counter.
- Sits as a general storage/control-bit block inside the lab datapaths.

Parameters:
- WIDTH, 8, number of independent storage bits.
- ERR_CNT_W, 4, width of the saturating invalid-input event counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- En  input  1  update enable; when 0, Q holds and no error is logged.
- Mode  input  2  00 SR, 01 JK, 10 D, 11 T; sampled on each enabled edge.
- S  input  WIDTH  per-bit S / J / D / T input, depending on Mode.
- R  input  WIDTH  per-bit R / K input; ignored in D and T modes.
- ErrClr  input  1  synchronous clear of Err and ErrCnt.
- Q  output  WIDTH  stored state.
- QBar  output  WIDTH  always the bitwise complement of Q, including during reset; never equal to Q.
- Err  output  1  sticky flag: an invalid SR input was seen.
- ErrCnt  output  ERR_CNT_W  saturating count of edges with an invalid SR input.

Behaviour:
- Reset (Rst_n=0, asynchronous, immediate): Q=0, QBar=all 1s, Err=0, ErrCnt=0. The bank leaves reset on the first rising Clk edge with Rst_n=1. Reset asserted mid-operation overrides everything, with no partial updates.
- Latency: Q reflects inputs one Clk edge after sampling. Purely registered outputs; no combinational path from inputs to Q/QBar/Err/ErrCnt.
- Per bit i, on a rising edge with En=1:
  - SR mode: S=1,R=0 gives 1. S=0,R=1 gives 0. 00 holds. 11 is invalid: Q[i] holds.
  - JK mode: 10 sets, 01 resets, 00 holds, 11 toggles (Q[i] <= ~Q[i]).
  - D mode: Q[i] <= S[i].
  - T mode: Q[i] <= Q[i] ^ S[i].
- Invalid event: Mode=SR, En=1, and any bit has S&R=1. Counted once per edge regardless of how many bits are invalid.
- Error logging on an invalid event:
  - Err <= 1.
  - ErrCnt increments and saturates at 2^ERR_CNT_W-1 with no wrap.
- ErrClr (synchronous) has priority over logging on the same edge: Err <= 0, ErrCnt <= 0, and that edge's invalid event is dropped. ErrClr works regardless of En.
- En=0: Q, Err and ErrCnt hold, except that ErrClr still applies.
- Mode change takes effect on the same edge it is sampled. There is no settle cycle.

Optional Feature:
- Macro: SR_JK_REGISTER_LOAD_EN.
- Defined:
  - Adds ports Load (input 1) and LoadVal (input WIDTH).
  - Load=1 on an edge gives Q <= LoadVal, independent of En and Mode.
  - No error is logged on that edge, but ErrClr still applies.
- Undefined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package sr_jk_pkg holds:
  - Mode encodings: MODE_SR=2'b00, MODE_JK=2'b01, MODE_D=2'b10, MODE_T=2'b11.
  - A function that computes next-state for one bit from mode, s, r and q.
- Sub-module sr_jk_cell is a one-bit registered cell instantiated WIDTH times via generate.
- Error detection and the counter live in the top level.

Test Plan:
- Reset: assert Rst_n=0 mid-cycle with Q=8'hA5 -> Q=8'h00 and QBar=8'hFF immediately, without waiting for an edge; Err=0, ErrCnt=0.
- SR mode: S=8'h0F,R=8'hF0 -> Q=8'h0F. Then S=8'h01,R=8'h01 -> Q stays 8'h0F, Err=1, ErrCnt=1.
- JK toggle: Q=8'h0F, Mode=JK, S=R=8'hFF for 2 edges -> Q=8'hF0, then 8'h0F; Err stays 0.
- D/T modes:
  - D with S=8'h3C -> Q=8'h3C.
  - Then T with S=8'hFF -> Q=8'hC3.
  - Then En=0 with S=8'h55 -> Q stays 8'hC3.
- Saturation/clear, ERR_CNT_W=4:
  - 20 consecutive invalid SR edges -> ErrCnt=15.
  - ErrClr=1 together with another invalid edge -> Err=0, ErrCnt=0.
- With SR_JK_REGISTER_LOAD_EN: Load=1, LoadVal=8'h5A, Mode=SR, S=R=8'hFF -> Q=8'h5A, ErrCnt unchanged.
